// File: rtl/hidden_wires_pkg.sv
// ---------------------------------------------------------------------------
// hidden_wires_pkg
// Purpose : Shared definition of the hidden_wires channel. The channel has no
//           valid and no backpressure. A word is meaningful from the one
//           carrying sop=1 through the one carrying eop=1, inclusive.
// Contents: hidden_wires_t  channel word {sop, eop, data[31:0]}
//           channel         published channel value seen by consumers
//           connect()       publication helper; set=1 passes the value
//                           through, set=0 yields the idle word
// ---------------------------------------------------------------------------
package hidden_wires_pkg;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } hidden_wires_t;

   // Only one source is allowed per simulation, so a single package-level
   // variable is enough to carry the published channel to every consumer.
   hidden_wires_t channel;

   function automatic hidden_wires_t connect(input hidden_wires_t tmp, input logic set);
      return set ? tmp : hidden_wires_t'(0);
   endfunction

endpackage

// File: rtl/hidden_wires_source_if.sv
// ---------------------------------------------------------------------------
// hidden_wires_source_if
// Purpose : Valid/ready packet stream feeding hidden_wires_source.
// Signals : in_valid          beat valid (master -> slave)
//           in_ready          beat accepted when in_valid & in_ready (slave -> master)
//           in_startofpacket  first beat of a packet
//           in_endofpacket    last beat of a packet
//           in_data[31:0]     beat payload
// Modports: master  drives the stream
//           slave   the source module that consumes the stream
// ---------------------------------------------------------------------------
interface hidden_wires_source_if;

   logic        in_valid;
   logic        in_ready;
   logic        in_startofpacket;
   logic        in_endofpacket;
   logic [31:0] in_data;

   modport master (
      output in_valid,
      output in_startofpacket,
      output in_endofpacket,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_startofpacket,
      input  in_endofpacket,
      input  in_data,
      output in_ready
   );

endinterface

// File: rtl/hidden_wires_source.sv
// ---------------------------------------------------------------------------
// hidden_wires_source
// Purpose : Store-and-forward producer for the hidden_wires channel. Whole
//           packets are collected from a valid/ready stream. Each packet is
//           then burst out one word per cycle on a registered channel that has
//           no backpressure, so a packet always leaves contiguously.
// Params  : DEPTH  buffer size in 32-bit words = max packet length (power of 2, >=2)
//           CNT_W  width of the sent/dropped packet counters (they wrap)
// Ports   : clk           rising-edge clock
//           reset_n       synchronous, active-low reset
//           bus           slave side of the input stream (valid/ready/sop/eop/data)
//           wires_out     registered channel word, also published via connect()
//           err_pulse     one-cycle pulse on a framing error
//           drop_pulse    one-cycle pulse when a packet longer than DEPTH is dropped
//           pkts_sent     packets fully emitted
//           pkts_dropped  packets dropped for overflow
// ---------------------------------------------------------------------------
module hidden_wires_source
   import hidden_wires_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   hidden_wires_source_if.slave bus,
   output hidden_wires_t        wires_out,
   output logic                 err_pulse,
   output logic                 drop_pulse,
   output logic [CNT_W-1:0]     pkts_sent,
   output logic [CNT_W-1:0]     pkts_dropped
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      COLLECT,
      DISCARD,
      BURST
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [IW-1:0] rd;
   logic [IW-1:0] rd_next;
   logic          ready_en;
   logic          in_ready_int;
   logic          accept;
   logic          last_word;
   logic          err_next;
   logic          drop_next;
   logic          wr_en;
   logic [IW-1:0] wr_addr;
   logic [31:0]   mem [DEPTH];
   hidden_wires_t wires_next;

   assign accept    = bus.in_valid & in_ready_int;
   assign last_word = ({1'b0, rd} == (count - CW'(1)));
   assign bus.in_ready = in_ready_int;

   // State register plus all registered outputs. ready_en holds in_ready low
   // for the cycle that follows a reset edge. pkts_sent counts a packet in the
   // cycle after its eop word was on the channel, which is the cycle the
   // channel returns to idle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= COLLECT;
         count        <= '0;
         rd           <= '0;
         ready_en     <= 1'b0;
         wires_out    <= '0;
         err_pulse    <= 1'b0;
         drop_pulse   <= 1'b0;
         pkts_sent    <= '0;
         pkts_dropped <= '0;
      end else begin
         state        <= state_next;
         count        <= count_next;
         rd           <= rd_next;
         ready_en     <= 1'b1;
         wires_out    <= wires_next;
         err_pulse    <= err_next;
         drop_pulse   <= drop_next;
         pkts_sent    <= pkts_sent + CNT_W'(wires_out.eop);
         pkts_dropped <= pkts_dropped + CNT_W'(drop_next);
      end
   end

   // The packet buffer needs no reset. Stale words are never emitted because
   // the burst length always comes from the current packet's count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= bus.in_data;
      end
   end

   // Next-state logic. COLLECT stores beats until eop. A packet that exceeds
   // DEPTH is dropped: if it has not ended yet, DISCARD swallows the rest of it.
   // An sop beat always starts a fresh packet at buffer word 0, even when a
   // partial packet is abandoned. BURST walks rd from 0 to count-1.
   always_comb begin
      state_next = state;
      count_next = count;
      rd_next    = rd;
      err_next   = 1'b0;
      drop_next  = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      unique case (state)
         COLLECT: begin
            if (accept) begin
               if (bus.in_startofpacket) begin
                  wr_en      = 1'b1;
                  err_next   = (count != '0);
                  count_next = CW'(1);
                  if (bus.in_endofpacket) begin
                     state_next = BURST;
                  end
               end else if (count == '0) begin
                  err_next = 1'b1;
               end else if (count == FULL) begin
                  drop_next = 1'b1;
                  if (bus.in_endofpacket) begin
                     count_next = '0;
                  end else begin
                     state_next = DISCARD;
                  end
               end else begin
                  wr_en      = 1'b1;
                  wr_addr    = count[IW-1:0];
                  count_next = count + CW'(1);
                  if (bus.in_endofpacket) begin
                     state_next = BURST;
                  end
               end
            end
         end
         DISCARD: begin
            if (accept) begin
               if (bus.in_startofpacket) begin
                  err_next   = 1'b1;
                  wr_en      = 1'b1;
                  count_next = CW'(1);
                  state_next = bus.in_endofpacket ? BURST : COLLECT;
               end else if (bus.in_endofpacket) begin
                  count_next = '0;
                  state_next = COLLECT;
               end
            end
         end
         BURST: begin
            if (last_word) begin
               rd_next    = '0;
               count_next = '0;
               state_next = COLLECT;
            end else begin
               rd_next = rd + IW'(1);
            end
         end
         default: begin
            state_next = COLLECT;
         end
      endcase
   end

   // Output logic. The stream is ready outside BURST. The next channel word is
   // the buffer word at rd during BURST, and the idle word at all other times.
   always_comb begin
      in_ready_int = ready_en && (state != BURST);
      wires_next   = '0;
      if (state == BURST) begin
         wires_next.sop  = (rd == '0);
         wires_next.eop  = last_word;
         wires_next.data = mem[rd];
      end
   end

   // Every change of the registered channel is republished to consumers.
   always_comb begin
      hidden_wires_pkg::channel = hidden_wires_pkg::connect(wires_out, 1'b1);
   end

endmodule

// File: tb/tb_hidden_wires_source.sv
// ---------------------------------------------------------------------------
// tb_hidden_wires_source
// Purpose : Self-checking bench for hidden_wires_source. A table of packets is
//           driven through the input stream. Expected channel words go into a
//           queue and are compared as the channel produces them. Hand-written
//           sequences cover latency, framing errors and a mid-burst reset.
// ---------------------------------------------------------------------------
module tb_hidden_wires_source;
   import hidden_wires_pkg::*;

   localparam int DEPTH = 64;
   localparam int CNT_W = 16;
   localparam int BOUND = 300;

   typedef struct {
      int          len;
      logic [31:0] base;
      int          exp_sent;
      int          exp_dropped;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   hidden_wires_t    wires_out;
   logic             err_pulse;
   logic             drop_pulse;
   logic [CNT_W-1:0] pkts_sent;
   logic [CNT_W-1:0] pkts_dropped;

   int            checks = 0;
   int            failures = 0;
   int            err_seen = 0;
   int            drop_seen = 0;
   logic          in_pkt = 1'b0;
   hidden_wires_t expq[$];

   hidden_wires_source_if bus ();

   hidden_wires_source #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .wires_out    (wires_out),
      .err_pulse    (err_pulse),
      .drop_pulse   (drop_pulse),
      .pkts_sent    (pkts_sent),
      .pkts_dropped (pkts_dropped)
   );

   // 10 ns clock period.
   always #5 clk = ~clk;

   function automatic hidden_wires_t mkWord(input logic sop, input logic eop, input logic [31:0] data);
      hidden_wires_t w;
      w.sop  = sop;
      w.eop  = eop;
      w.data = data;
      return w;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drive one beat and hold it until the DUT accepts it, then release valid.
   // The task returns 1 ns after the accepting edge.
   task automatic applyStimulus(input logic sop, input logic eop, input logic [31:0] data);
      int n;
      n = 0;
      bus.in_valid         = 1'b1;
      bus.in_startofpacket = sop;
      bus.in_endofpacket   = eop;
      bus.in_data          = data;
      while (!bus.in_ready && n < BOUND) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= BOUND) begin
         checkOutput("ready_timeout", 64'(n), 64'(0));
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Wait until every expected word has been seen and the channel is idle and
   // ready again. The first cycle is always waited so that the monitor can
   // count any pulse from the last accepted beat.
   task automatic waitIdle();
      int n;
      n = 0;
      @(posedge clk);
      #1;
      while (!(expq.size() == 0 && bus.in_ready && wires_out == '0) && n < BOUND) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= BOUND) begin
         checkOutput("idle_timeout", 64'(n), 64'(0));
      end
   endtask

   // Consumer model: words from sop through eop are popped from the queue and
   // compared on both the port and the published channel. Outside a packet,
   // the channel must carry the idle word.
   always @(negedge clk) begin : monitor
      hidden_wires_t exp_w;
      if (err_pulse) err_seen++;
      if (drop_pulse) drop_seen++;
      if (wires_out.sop || in_pkt) begin
         if (wires_out.sop) in_pkt = 1'b1;
         if (expq.size() == 0) begin
            checkOutput("unexpected_word", 64'(wires_out), 64'(0));
         end else begin
            exp_w = expq.pop_front();
            checkOutput("burst_word", 64'(wires_out), 64'(exp_w));
            checkOutput("published_word", 64'(hidden_wires_pkg::channel), 64'(exp_w));
         end
         if (wires_out.eop) in_pkt = 1'b0;
      end else begin
         checkOutput("idle_channel", 64'(wires_out), 64'(0));
         checkOutput("idle_published", 64'(hidden_wires_pkg::channel), 64'(0));
      end
      if (!reset_n) in_pkt = 1'b0;
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, packet table, then the hand-written corner cases.
   initial begin
      vec_t        vecs[6];
      logic [31:0] d;
      int          err0;

      vecs[0] = '{len: 4,  base: 32'h0000_00A0, exp_sent: 1, exp_dropped: 0};
      vecs[1] = '{len: 1,  base: 32'hDEAD_BEEF, exp_sent: 2, exp_dropped: 0};
      vecs[2] = '{len: 65, base: 32'h0000_1000, exp_sent: 2, exp_dropped: 1};
      vecs[3] = '{len: 2,  base: 32'h0000_2000, exp_sent: 3, exp_dropped: 1};
      vecs[4] = '{len: 64, base: 32'h0000_3000, exp_sent: 4, exp_dropped: 1};
      vecs[5] = '{len: 3,  base: 32'h0000_4000, exp_sent: 5, exp_dropped: 1};

      bus.in_valid         = 1'b0;
      bus.in_startofpacket = 1'b0;
      bus.in_endofpacket   = 1'b0;
      bus.in_data          = '0;
      reset_n              = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", 64'(bus.in_ready), 64'(0));
      checkOutput("reset_wires", 64'(wires_out), 64'(0));
      checkOutput("reset_sent", 64'(pkts_sent), 64'(0));
      checkOutput("reset_dropped", 64'(pkts_dropped), 64'(0));
      checkOutput("reset_err", 64'(err_pulse), 64'(0));
      checkOutput("reset_drop", 64'(drop_pulse), 64'(0));
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready_after_release", 64'(bus.in_ready), 64'(1));

      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < vecs[v].len; i++) begin
            d = vecs[v].base + 32'(i);
            if (vecs[v].len <= DEPTH) begin
               expq.push_back(mkWord(i == 0, i == vecs[v].len - 1, d));
            end
            applyStimulus(i == 0, i == vecs[v].len - 1, d);
         end
         waitIdle();
         checkOutput("vec_sent", 64'(pkts_sent), 64'(vecs[v].exp_sent));
         checkOutput("vec_dropped", 64'(pkts_dropped), 64'(vecs[v].exp_dropped));
         checkOutput("vec_drop_pulses", 64'(drop_seen), 64'(vecs[v].exp_dropped));
         checkOutput("vec_err_pulses", 64'(err_seen), 64'(0));
      end

      // Latency of a 4-word burst relative to the accepting edge of its eop.
      for (int i = 0; i < 4; i++) begin
         expq.push_back(mkWord(i == 0, i == 3, 32'hC0 + 32'(i)));
         applyStimulus(i == 0, i == 3, 32'hC0 + 32'(i));
      end
      checkOutput("lat_ready_low_n", 64'(bus.in_ready), 64'(0));
      checkOutput("lat_idle_n", 64'(wires_out), 64'(0));
      @(posedge clk);
      #1;
      checkOutput("lat_word0", 64'(wires_out), 64'(mkWord(1'b1, 1'b0, 32'hC0)));
      checkOutput("lat_ready_low_n1", 64'(bus.in_ready), 64'(0));
      repeat (2) begin
         @(posedge clk);
         #1;
         checkOutput("lat_ready_low_mid", 64'(bus.in_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      checkOutput("lat_word3", 64'(wires_out), 64'(mkWord(1'b0, 1'b1, 32'hC3)));
      checkOutput("lat_ready_back", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;
      checkOutput("lat_idle_after", 64'(wires_out), 64'(0));
      checkOutput("lat_sent", 64'(pkts_sent), 64'(6));

      // Stray beat, then a packet restarted by a second sop: two errors, and
      // only the 2-word tail packet is emitted.
      err0 = err_seen;
      applyStimulus(1'b0, 1'b0, 32'h5555);
      checkOutput("stray_err_pulse", 64'(err_pulse), 64'(1));
      expq.push_back(mkWord(1'b1, 1'b0, 32'h6001));
      expq.push_back(mkWord(1'b0, 1'b1, 32'h6002));
      applyStimulus(1'b1, 1'b0, 32'h6000);
      checkOutput("sop_no_err", 64'(err_pulse), 64'(0));
      applyStimulus(1'b1, 1'b0, 32'h6001);
      checkOutput("restart_err_pulse", 64'(err_pulse), 64'(1));
      applyStimulus(1'b0, 1'b1, 32'h6002);
      checkOutput("tail_no_err", 64'(err_pulse), 64'(0));
      waitIdle();
      checkOutput("framing_err_count", 64'(err_seen), 64'(err0 + 2));
      checkOutput("framing_sent", 64'(pkts_sent), 64'(7));

      // Reset while word 2 of an 8-word burst is on the channel.
      for (int i = 0; i < 8; i++) begin
         expq.push_back(mkWord(i == 0, i == 7, 32'h7000 + 32'(i)));
         applyStimulus(i == 0, i == 7, 32'h7000 + 32'(i));
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("rst_word2_visible", 64'(wires_out), 64'(mkWord(1'b0, 1'b0, 32'h7002)));
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_wires", 64'(wires_out), 64'(0));
      checkOutput("rst_published", 64'(hidden_wires_pkg::channel), 64'(0));
      checkOutput("rst_sent", 64'(pkts_sent), 64'(0));
      checkOutput("rst_dropped", 64'(pkts_dropped), 64'(0));
      checkOutput("rst_ready", 64'(bus.in_ready), 64'(0));
      checkOutput("rst_leftover_words", 64'(expq.size()), 64'(5));
      expq.delete();
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_ready_release", 64'(bus.in_ready), 64'(1));

      // The DUT must accept and emit a normal packet after the reset.
      for (int i = 0; i < 2; i++) begin
         expq.push_back(mkWord(i == 0, i == 1, 32'h8000 + 32'(i)));
         applyStimulus(i == 0, i == 1, 32'h8000 + 32'(i));
      end
      waitIdle();
      checkOutput("recover_sent", 64'(pkts_sent), 64'(1));
      checkOutput("recover_dropped", 64'(pkts_dropped), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
